// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the core it feeds:
// loader FSM states, default address/word widths and the core opcode map.
package prog_loader_pkg;

    localparam int D_DEF = 12;  // program-address width, matches the core PC
    localparam int W_DEF = 9;   // machine-code word width

    typedef enum logic [2:0] {
        S_LOAD,
        S_ARM,
        S_REQ,
        S_RUN,
        S_FIN
    } state_t;

    // Core opcodes live in the top three bits of a machine-code word.
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_JMP  = 3'd5,
        OP_JZ   = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    function automatic opcode_t opcode_of(input logic [W_DEF-1:0] word);
        return opcode_t'(word[W_DEF-1 -: OP_W]);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Host-to-instruction-ROM program loader: streams words into the ROM write
// port, then releases the core, starts it, and waits for completion.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int D = D_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         core_rst,
    output logic         req,
    input  logic         core_done,
    input  logic         start,
    output logic [D-1:0] prog_len,
    output logic         done,
    output logic         ovf
);

    localparam logic [D-1:0] LAST_ADDR = '1;

    state_t       state;
    logic [D-1:0] count;
    logic         rerun;   // FIN sub-phase holding core_rst for one cycle
    logic         accept;
    logic         at_cap;

    // The ROM strobe must land in the same cycle as the handshake, so the
    // write port is decoded combinationally from the registered in_ready.
    assign accept   = in_valid && in_ready;
    assign at_cap   = (count == LAST_ADDR);
    assign wr_en    = accept;
    assign wr_addr  = count;
    assign wr_data  = in_data;
    assign prog_len = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_LOAD;
            count    <= '0;
            ovf      <= 1'b0;
            rerun    <= 1'b0;
            in_ready <= 1'b1;
            core_rst <= 1'b1;
            req      <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so that all of them sample
            // the pre-edge state; req defaults low and is raised only in ARM.
            req <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (!at_cap) begin
                            count <= count + 1'b1;
                        end
                        // The top address is the last slot; without in_last
                        // the program is truncated there instead of wrapping.
                        if (in_last || at_cap) begin
                            ovf      <= !in_last;
                            state    <= S_ARM;
                            in_ready <= 1'b0;
                            core_rst <= 1'b0;
                        end
                    end
                end
                S_ARM: begin
                    state <= S_REQ;
                    req   <= 1'b1;
                end
                S_REQ: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (core_done) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    if (rerun) begin
                        rerun    <= 1'b0;
                        core_rst <= 1'b0;
                        state    <= S_ARM;
                    end else if (start) begin
                        // Rerun: pulse core_rst so the PC restarts from 0,
                        // keeping the ROM contents and prog_len.
                        rerun    <= 1'b1;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                    end else if (in_valid) begin
                        state    <= S_LOAD;
                        count    <= '0;
                        ovf      <= 1'b0;
                        in_ready <= 1'b1;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_LOAD;
                    count    <= '0;
                    ovf      <= 1'b0;
                    rerun    <= 1'b0;
                    in_ready <= 1'b1;
                    core_rst <= 1'b1;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
